spi_controller_avalon_host: RTL and testbench

- Avalon-MM master that drives the SPI controller's Avalon-MM slave/debug port from a simple command/response interface.
- Accepts one command at a time (single read or write) and issues it on the Avalon bus, honouring waitrequest.
- For reads, captures readdata and returns it on a response channel.
- Sits between the test/debug sequencer (or CPU bridge) and the SPI controller's slave port.

---
 rtl/spi_controller_avalon_host.sv | 109 ++++++++++
 tb/tb_spi_controller_avalon_host.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/spi_controller_avalon_host.sv
// spi_controller_avalon_host: single-outstanding command/response to Avalon-MM master bridge.
// Optional waitrequest timeout abort enabled by defining SPI_AVALON_HOST_TIMEOUT_EN.
module spi_controller_avalon_host #(
  parameter int DATA_WIDTH     = 64,
  parameter int ADDR_WIDTH     = 1,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  io_Cmd_valid,
  output logic                  io_Cmd_ready,
  input  logic                  io_Cmd_write,
  input  logic [ADDR_WIDTH-1:0] io_Cmd_address,
  input  logic [DATA_WIDTH-1:0] io_Cmd_data,
  output logic                  io_Rsp_valid,
  input  logic                  io_Rsp_ready,
  output logic [DATA_WIDTH-1:0] io_Rsp_data,
  output logic                  io_Rsp_error,
  output logic [ADDR_WIDTH-1:0] io_Avalon_address,
  output logic                  io_Avalon_read,
  output logic                  io_Avalon_write,
  output logic [DATA_WIDTH-1:0] io_Avalon_writedata,
  input  logic [DATA_WIDTH-1:0] io_Avalon_readdata,
  input  logic                  io_Avalon_waitrequest
);
  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;
  state_t state_q, state_d;
  logic cmd_ready_q, cmd_ready_d, rsp_valid_q, rsp_valid_d, rsp_error_q, rsp_error_d;
  logic rd_q, rd_d, wr_q, wr_d, busy, done, tmo;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d, wdata_q, wdata_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  assign busy = state_q == READ || state_q == WRITE;
  assign done = busy && !io_Avalon_waitrequest;
`ifdef SPI_AVALON_HOST_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  // Counts stalled strobe cycles; abort fires on the stall that reaches the limit
  assign cnt_d = busy ? cnt_q + CW'(io_Avalon_waitrequest) : '0;
  assign tmo = busy && io_Avalon_waitrequest && cnt_q == CW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clock)
    cnt_q <= !reset ? '0 : cnt_d;
`else
  assign tmo = TIMEOUT_CYCLES < 0;
`endif
  always_comb begin
    state_d     = state_q;
    rsp_valid_d = rsp_valid_q;
    rsp_error_d = rsp_error_q;
    rsp_data_d  = rsp_data_q;
    rd_d        = rd_q;
    wr_d        = wr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    case (state_q)
      IDLE: if (io_Cmd_valid && cmd_ready_q) begin
        state_d = io_Cmd_write ? WRITE : READ;
        rd_d    = !io_Cmd_write;
        wr_d    = io_Cmd_write;
        addr_d  = io_Cmd_address;
        wdata_d = io_Cmd_data;
      end
      READ, WRITE: if (done || tmo) begin
        state_d     = RESP;
        rd_d        = 1'b0;
        wr_d        = 1'b0;
        rsp_valid_d = 1'b1;
        rsp_error_d = !done;
        rsp_data_d  = (done && state_q == READ) ? io_Avalon_readdata : '0;
      end
      RESP: if (io_Rsp_ready) begin
        state_d     = IDLE;
        rsp_valid_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
    cmd_ready_d = state_d == IDLE;
  end
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_error_q <= 1'b0;
      rsp_data_q  <= '0;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_error_q <= rsp_error_d;
      rsp_data_q  <= rsp_data_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
    end
  end
  assign io_Cmd_ready        = cmd_ready_q;
  assign io_Rsp_valid        = rsp_valid_q;
  assign io_Rsp_data         = rsp_data_q;
  assign io_Rsp_error        = rsp_error_q;
  assign io_Avalon_address   = addr_q;
  assign io_Avalon_read      = rd_q;
  assign io_Avalon_write     = wr_q;
  assign io_Avalon_writedata = wdata_q;
endmodule

// File: tb/tb_spi_controller_avalon_host.sv
// tb_spi_controller_avalon_host: table-driven cycle trace plus reset-abort and timeout sequences.
module tb_spi_controller_avalon_host;
  logic clock = 1'b0, reset = 1'b0;
  logic io_Cmd_valid = 1'b0, io_Cmd_write = 1'b0, io_Rsp_ready = 1'b0, io_Avalon_waitrequest = 1'b0;
  logic [0:0] io_Cmd_address = '0;
  logic [63:0] io_Cmd_data = '0, io_Avalon_readdata = '0;
  logic io_Cmd_ready, io_Rsp_valid, io_Rsp_error, io_Avalon_read, io_Avalon_write;
  logic [63:0] io_Rsp_data, io_Avalon_writedata;
  logic [0:0] io_Avalon_address;
  int checks = 0, errors = 0;
  spi_controller_avalon_host #(.DATA_WIDTH(64), .ADDR_WIDTH(1), .TIMEOUT_CYCLES(10)) dut (
    .clock(clock), .reset(reset),
    .io_Cmd_valid(io_Cmd_valid), .io_Cmd_ready(io_Cmd_ready), .io_Cmd_write(io_Cmd_write),
    .io_Cmd_address(io_Cmd_address), .io_Cmd_data(io_Cmd_data),
    .io_Rsp_valid(io_Rsp_valid), .io_Rsp_ready(io_Rsp_ready), .io_Rsp_data(io_Rsp_data),
    .io_Rsp_error(io_Rsp_error), .io_Avalon_address(io_Avalon_address), .io_Avalon_read(io_Avalon_read),
    .io_Avalon_write(io_Avalon_write), .io_Avalon_writedata(io_Avalon_writedata),
    .io_Avalon_readdata(io_Avalon_readdata), .io_Avalon_waitrequest(io_Avalon_waitrequest)
  );
  always #5 clock = ~clock;
  typedef struct {
    logic rst_n, v, w, a;
    logic [63:0] d;
    logic rr;
    logic [63:0] rdat;
    logic wq;
    logic cr, rv;
    logic [63:0] rdt;
    logic re, ar, aw, aa;
    logic [63:0] awd;
  } vec_t;
  vec_t tbl[25];
  function automatic vec_t mk(logic rst_n, v, w, a, logic [63:0] d, logic rr, logic [63:0] rdat, logic wq,
                              logic cr, rv, logic [63:0] rdt, logic re, ar, aw, aa, logic [63:0] awd);
    vec_t t;
    t.rst_n = rst_n; t.v = v; t.w = w; t.a = a; t.d = d; t.rr = rr; t.rdat = rdat; t.wq = wq;
    t.cr = cr; t.rv = rv; t.rdt = rdt; t.re = re; t.ar = ar; t.aw = aw; t.aa = aa; t.awd = awd;
    return t;
  endfunction
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  // Response data/error are only compared while a response is expected, or when strict (reset state)
  task automatic check(string nm, logic strict, logic cr, rv, logic [63:0] rdt, logic re, ar, aw, aa, logic [63:0] awd);
    logic [63:0] ard;
    logic are;
    ard = (rv || strict) ? io_Rsp_data : rdt;
    are = (rv || strict) ? io_Rsp_error : re;
    checks++;
    if ({io_Cmd_ready, io_Rsp_valid, ard, are, io_Avalon_read, io_Avalon_write, io_Avalon_address[0], io_Avalon_writedata}
        !== {cr, rv, rdt, re, ar, aw, aa, awd}) begin
      errors++;
      $display("FAIL %s: got cr=%b rv=%b rdata=%h err=%b rd=%b wr=%b addr=%b wdata=%h, expected cr=%b rv=%b rdata=%h err=%b rd=%b wr=%b addr=%b wdata=%h",
               nm, io_Cmd_ready, io_Rsp_valid, io_Rsp_data, io_Rsp_error, io_Avalon_read, io_Avalon_write,
               io_Avalon_address[0], io_Avalon_writedata, cr, rv, rdt, re, ar, aw, aa, awd);
    end
  endtask
  localparam logic [63:0] D = 64'hDEAD_BEEF_0000_0001, R = 64'h200, P = 64'h0123_4567_89AB_CDEF;
  initial begin
    for (int i = 0; i < 3; i++) tbl[i] = mk(0,1,0,1,D,0,R,0, 0,0,0,0,0,0,0,0);
    tbl[3] = mk(1,0,0,0,0,0,R,0, 1,0,0,0,0,0,0,0);
    tbl[4] = mk(1,1,0,0,0,0,R,0, 0,0,0,0,1,0,0,0);
    tbl[5] = mk(1,0,0,0,0,0,R,0, 0,1,R,0,0,0,0,0);
    for (int i = 6; i < 12; i++) tbl[i] = mk(1,1,1,1,D,0,64'h1234,0, 0,1,R,0,0,0,0,0);
    tbl[12] = mk(1,1,1,1,D,1,64'h1234,0, 1,0,R,0,0,0,0,0);
    tbl[13] = mk(1,1,1,1,D,0,0,1, 0,0,0,0,0,1,1,D);
    for (int i = 14; i < 18; i++) tbl[i] = mk(1,0,0,0,0,0,'1,1, 0,0,0,0,0,1,1,D);
    tbl[18] = mk(1,0,0,0,0,0,'1,0, 0,1,0,0,0,0,1,D);
    tbl[19] = mk(1,0,0,0,0,1,0,0, 1,0,0,0,0,0,1,D);
    tbl[20] = mk(1,0,0,0,0,0,0,0, 1,0,0,0,0,0,1,D);
    tbl[21] = mk(1,1,0,1,0,0,0,1, 0,0,0,0,1,0,1,0);
    tbl[22] = mk(1,0,0,0,0,0,64'hAAAA,1, 0,0,0,0,1,0,1,0);
    tbl[23] = mk(1,0,0,0,0,0,P,0, 0,1,P,0,0,0,1,0);
    tbl[24] = mk(1,0,0,0,0,1,0,0, 1,0,0,0,0,0,1,0);
    #1;
    for (int i = 0; i < 25; i++) begin
      reset = tbl[i].rst_n; io_Cmd_valid = tbl[i].v; io_Cmd_write = tbl[i].w; io_Cmd_address = tbl[i].a;
      io_Cmd_data = tbl[i].d; io_Rsp_ready = tbl[i].rr; io_Avalon_readdata = tbl[i].rdat;
      io_Avalon_waitrequest = tbl[i].wq;
      tick();
      check($sformatf("row%0d", i), !tbl[i].rst_n, tbl[i].cr, tbl[i].rv, tbl[i].rdt, tbl[i].re,
            tbl[i].ar, tbl[i].aw, tbl[i].aa, tbl[i].awd);
    end
    // reset during a stalled read
    io_Cmd_valid = 1; io_Cmd_write = 0; io_Cmd_address = 0; io_Cmd_data = 0; io_Rsp_ready = 0;
    io_Avalon_waitrequest = 1; io_Avalon_readdata = 64'h5555;
    tick();
    io_Cmd_valid = 0;
    check("midrd_acc", 0, 0,0,0,0,1,0,0,0);
    tick();
    check("midrd_stall", 0, 0,0,0,0,1,0,0,0);
    reset = 0;
    tick();
    check("midrd_rst", 1, 0,0,0,0,0,0,0,0);
    reset = 1; io_Avalon_waitrequest = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("midrd_norsp%0d", k), 1, 1,0,0,0,0,0,0,0);
    end
`ifdef SPI_AVALON_HOST_TIMEOUT_EN
    io_Cmd_valid = 1; io_Cmd_address = 1; io_Avalon_waitrequest = 1; io_Avalon_readdata = 64'h99;
    tick();
    io_Cmd_valid = 0;
    check("tmo_acc", 0, 0,0,0,0,1,0,1,0);
    for (int k = 1; k < 10; k++) begin
      tick();
      check($sformatf("tmo_stall%0d", k), 0, 0,0,0,0,1,0,1,0);
    end
    tick();
    check("tmo_abort", 0, 0,1,0,1,0,0,1,0);
    io_Rsp_ready = 1;
    tick();
    io_Rsp_ready = 0;
    check("tmo_hs", 0, 1,0,0,0,0,0,1,0);
    io_Cmd_valid = 1;
    tick();
    io_Cmd_valid = 0;
    check("tmo2_acc", 0, 0,0,0,0,1,0,1,0);
    for (int k = 1; k < 9; k++) begin
      tick();
      check($sformatf("tmo2_stall%0d", k), 0, 0,0,0,0,1,0,1,0);
    end
    io_Avalon_waitrequest = 0; io_Avalon_readdata = 64'h77;
    tick();
    check("tmo2_done", 0, 0,1,64'h77,0,0,0,1,0);
`else
    io_Cmd_valid = 1; io_Cmd_address = 1; io_Avalon_waitrequest = 1; io_Avalon_readdata = 64'h99;
    tick();
    io_Cmd_valid = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      check($sformatf("nto_stall%0d", k), 0, 0,0,0,0,1,0,1,0);
    end
    io_Avalon_waitrequest = 0; io_Avalon_readdata = 64'h77;
    tick();
    check("nto_done", 0, 0,1,64'h77,0,0,0,1,0);
`endif
    io_Rsp_ready = 1;
    tick();
    io_Rsp_ready = 0;
    check("final_hs", 0, 1,0,0,0,0,0,1,0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
